ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Parametrised PS/2 scan-code decoder that sits directly behind PS2_Controller and replaces per-key "last key pressed" flags with true per-key held state. It tracks make/break (F0) and extended (E0) prefixes, suppresses typematic repeats, emits one-cycle make/break pulses, and queues key events in a small FIFO for the game FSM. Up to NUM_KEYS keys are mapped by parameter.

Parameters:
NUM_KEYS, 8, number of mapped keys; key index i is 0..NUM_KEYS-1
KEY_CODES, {8'h72,8'h75,8'h5a,8'h29,8'h23,8'h1c,8'h1b,8'h1d}, packed 8*NUM_KEYS; key i code at bits [8i+7:8i] (idx0 W, 1 S, 2 A, 3 D, 4 space, 5 enter, 6 up-arrow, 7 down-arrow)
KEY_EXT, 8'b1100_0000, bit i = 1: key i requires the E0 prefix
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2
PREFIX_TIMEOUT, 100000, idle clk cycles after a prefix byte before the decoder abandons the sequence (2 ms at 50 MHz)
REPEAT_EVENTS, 0, 1 = typematic repeats of a held key also push a make event (no pulse)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset
clear  in  1  sync clear of held state, FIFO, decoder state and overflow (game-state erase)
rx_data  in  8  byte from PS2_Controller received_data
rx_valid  in  1  one-cycle strobe, rx_data valid (received_data_en)
key_held  out  NUM_KEYS  bit i = 1 while key i is down
key_make  out  NUM_KEYS  one-cycle pulse on first make of key i
key_break  out  NUM_KEYS  one-cycle pulse on break of a held key i
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pop; pop occurs when evt_valid & evt_ready
evt_index  out  $clog2(NUM_KEYS) (min 1)  key index at FIFO head
evt_is_break  out  1  head event: 1 = break, 0 = make
evt_overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- All outputs registered. Reset (reset==0 at posedge): key_held=0, key_make=0, key_break=0, FIFO empty (evt_valid=0, evt_index=0, evt_is_break=0), evt_overflow=0, FSM IDLE, timeout counter 0. Reset has priority over clear and rx_valid.
- clear=1 (reset high): same effect as reset on all state; an rx_valid byte in the same cycle is dropped; evt_ready ignored.
- FSM states IDLE, E0, F0, E0F0, acting only on rx_valid:
  IDLE: 8'hE0->E0; 8'hF0->F0; else resolve(ext=0,brk=0).
  E0: 8'hF0->E0F0; 8'hE0 stays E0; else resolve(ext=1,brk=0).
  F0: resolve(ext=0,brk=1).  E0F0: resolve(ext=1,brk=1).
  resolve always returns to IDLE.
- Ignored bytes (any state, ->IDLE, no effect): 8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF. Pause sequence tail bytes arriving afterwards resolve as ordinary codes and match nothing by default.
- resolve: lowest index i with KEY_CODES[i]==rx_data and KEY_EXT[i]==ext. No match: no effect.
  make, held[i]=0: held[i]<=1, key_make[i] pulses, push {i,0}.
  make, held[i]=1 (typematic): no pulse; push {i,0} only if REPEAT_EVENTS=1.
  break, held[i]=1: held[i]<=0, key_break[i] pulses, push {i,1}.
  break, held[i]=0: no effect.
- Latency: byte strobed at edge N; key_held, pulses and evt_valid update at edge N+1 (visible the cycle after). Pulses are high exactly one cycle.
- Timeout: in E0/F0/E0F0, counter increments each cycle without rx_valid; reaching PREFIX_TIMEOUT-1 forces IDLE and zeroes the counter. Counter is 0 in IDLE and on every rx_valid.
- FIFO: at most one push per cycle. Push when full and no pop: event dropped, evt_overflow<=1 (sticky until reset/clear); held/pulses still update. Push and pop in the same cycle while full: both occur, nothing lost. Pop when empty: ignored. Head fields hold their value while evt_valid=0.
- Multiple keys may be held at once; held bits are independent.

Test Plan:
- Reset then bytes 1D, 1C -> key_held=8'b0000_0101; key_make[0] then key_make[2] each one cycle; FIFO holds {0,make},{2,make}.
- Bytes 1D,1D,1D (typematic), F0,1D, REPEAT_EVENTS=0 -> one make pulse, one break pulse, held[0] 1->0, exactly 2 FIFO events.
- Bytes E0,75 then E0,F0,75 -> held[6] set then cleared; bare 75 (no E0) -> no effect (keypad 8 ignored).
- Six distinct make events with evt_ready=0, FIFO_DEPTH=4 -> first 4 kept, evt_overflow=1, key_held shows all 6 keys; then pop all -> evt_valid drops after 4 pops, overflow stays 1 until clear.
- Byte E0 then 100000 idle cycles then 1D -> decoded as W make (not extended), held[0]=1.
- Hold keys 0 and 4, assert clear together with rx_valid=F0 -> key_held=0, FIFO empty, overflow=0; following 1D decodes as make.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, keeps per-key held state,
// emits one-cycle make/break pulses and queues key events in a small FIFO.
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 8,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h72, 8'h75, 8'h5a, 8'h29,
                                                       8'h23, 8'h1c, 8'h1b, 8'h1d},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 8'b1100_0000,
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    PREFIX_TIMEOUT = 100000,
    parameter bit                    REPEAT_EVENTS  = 1'b0,
    localparam int                   IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_make,
    output logic [NUM_KEYS-1:0] key_break,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_index,
    output logic                evt_is_break,
    output logic                evt_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t          state;
    logic [TO_W-1:0] idle_cnt;

    // Controller acks, BAT results and Pause-sequence heads carry no key meaning.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic                ext;
    logic                brk;
    logic                is_prefix;
    logic                resolve;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit_held;
    logic [NUM_KEYS-1:0] onehot;
    logic                do_make;
    logic                do_rep;
    logic                do_brk;

    always_comb begin
        ext       = (state == S_E0) || (state == S_E0F0);
        brk       = (state == S_F0) || (state == S_E0F0);
        is_prefix = ((state == S_IDLE) || (state == S_E0)) &&
                    ((rx_data == 8'hE0) || (rx_data == 8'hF0));
        resolve   = rx_valid && !is_ignored(rx_data) && !is_prefix;
        hit       = 1'b0;
        hit_idx   = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if ((KEY_CODES[8*i +: 8] == rx_data) && (KEY_EXT[i] == ext)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit_held = key_held[hit_idx];
        onehot   = NUM_KEYS'(1) << hit_idx;
        do_make  = resolve && hit && !brk && !hit_held;
        do_rep   = resolve && hit && !brk && hit_held && REPEAT_EVENTS;
        do_brk   = resolve && hit && brk && hit_held;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
        end else if (rx_valid) begin
            idle_cnt <= '0;
            if (is_ignored(rx_data)) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == 8'hE0)      state <= S_E0;
                        else if (rx_data == 8'hF0) state <= S_F0;
                        else                       state <= S_IDLE;
                    end
                    S_E0: begin
                        if (rx_data == 8'hF0)      state <= S_E0F0;
                        else if (rx_data == 8'hE0) state <= S_E0;
                        else                       state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end else if (state != S_IDLE) begin
            // A prefix left dangling (e.g. lost byte) must not taint later codes.
            if (idle_cnt == TO_LAST) begin
                state    <= S_IDLE;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            key_held  <= '0;
            key_make  <= '0;
            key_break <= '0;
        end else begin
            key_make  <= do_make ? onehot : '0;
            key_break <= do_brk  ? onehot : '0;
            if (do_make)     key_held <= key_held | onehot;
            else if (do_brk) key_held <= key_held & ~onehot;
        end
    end

    logic [IDX_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [IDX_W:0]   push_data;
    logic [IDX_W:0]   head_nxt;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;

    always_comb begin
        push_req  = do_make || do_rep || do_brk;
        push_data = {do_brk, hit_idx};
        pop       = evt_valid && evt_ready;
        full      = (count == FULL);
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        rd_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt = count;
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (!push && pop) count_nxt = count - 1'b1;
        // The entry being written this cycle becomes head when the queue was (or goes) empty.
        head_nxt  = (push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_valid    <= 1'b0;
            evt_index    <= '0;
            evt_is_break <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            evt_valid <= (count_nxt != '0);
            if (count_nxt != '0) {evt_is_break, evt_index} <= head_nxt;
            if (drop) evt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: make/break, typematic, extended keys,
// ignored bytes, FIFO overflow and full push+pop, prefix timeout, clear.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] key_held;
    logic [7:0] key_make;
    logic [7:0] key_break;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_index;
    logic       evt_is_break;
    logic       evt_overflow;

    int tests = 0;
    int fails = 0;

    ps2_key_decoder #(.PREFIX_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .key_held(key_held), .key_make(key_make), .key_break(key_break),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
        .evt_is_break(evt_is_break), .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge; outputs are checked there.
    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_held", key_held, 8'h00);
        chk("rst_make", key_make, 8'h00);
        chk("rst_break", key_break, 8'h00);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_index", evt_index, 3'd0);
        chk("rst_isbrk", evt_is_break, 1'b0);
        chk("rst_ovf", evt_overflow, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // W then A
        send(8'h1D);
        chk("w_held", key_held, 8'h01);
        chk("w_make", key_make, 8'h01);
        chk("w_valid", evt_valid, 1'b1);
        chk("w_index", evt_index, 3'd0);
        chk("w_isbrk", evt_is_break, 1'b0);
        send(8'h1C);
        chk("wa_held", key_held, 8'h05);
        chk("a_make", key_make, 8'h04);
        @(negedge clk);
        chk("a_make_gone", key_make, 8'h00);
        pop();
        chk("pop1_index", evt_index, 3'd2);
        chk("pop1_valid", evt_valid, 1'b1);
        pop();
        chk("pop2_valid", evt_valid, 1'b0);
        chk("empty_hold_index", evt_index, 3'd2);

        // typematic repeats then break
        clr();
        chk("clr_held", key_held, 8'h00);
        send(8'h1D);
        chk("tm_make1", key_make, 8'h01);
        send(8'h1D);
        chk("tm_make2", key_make, 8'h00);
        chk("tm_held2", key_held, 8'h01);
        send(8'h1D);
        send(8'hF0);
        chk("tm_f0_held", key_held, 8'h01);
        chk("tm_f0_break", key_break, 8'h00);
        send(8'h1D);
        chk("tm_break", key_break, 8'h01);
        chk("tm_held_off", key_held, 8'h00);
        @(negedge clk);
        chk("tm_break_gone", key_break, 8'h00);
        chk("tm_ev1_index", evt_index, 3'd0);
        chk("tm_ev1_isbrk", evt_is_break, 1'b0);
        pop();
        chk("tm_ev2_valid", evt_valid, 1'b1);
        chk("tm_ev2_isbrk", evt_is_break, 1'b1);
        pop();
        chk("tm_only2", evt_valid, 1'b0);

        // extended up-arrow, bare keypad-8, ignored byte after E0
        send(8'hE0);
        send(8'h75);
        chk("up_held", key_held, 8'h40);
        chk("up_make", key_make, 8'h40);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("up_break", key_break, 8'h40);
        chk("up_held_off", key_held, 8'h00);
        send(8'h75);
        chk("kp8_held", key_held, 8'h00);
        chk("kp8_make", key_make, 8'h00);
        send(8'hE0);
        send(8'hFA);
        send(8'h75);
        chk("ign_held", key_held, 8'h00);
        chk("up_ev1_index", evt_index, 3'd6);
        chk("up_ev1_isbrk", evt_is_break, 1'b0);
        pop();
        chk("up_ev2_index", evt_index, 3'd6);
        chk("up_ev2_isbrk", evt_is_break, 1'b1);
        pop();
        chk("up_only2", evt_valid, 1'b0);

        // overflow with six makes
        clr();
        send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
        chk("ovf_at4", evt_overflow, 1'b0);
        send(8'h29);
        chk("ovf_at5", evt_overflow, 1'b1);
        chk("ovf_held5", key_held, 8'h1F);
        send(8'h5A);
        chk("ovf_held6", key_held, 8'h3F);
        chk("ovf_head", evt_index, 3'd0);
        pop();
        chk("ovf_pop1", evt_index, 3'd1);
        pop();
        chk("ovf_pop2", evt_index, 3'd2);
        pop();
        chk("ovf_pop3", evt_index, 3'd3);
        chk("ovf_pop3_valid", evt_valid, 1'b1);
        pop();
        chk("ovf_pop4_valid", evt_valid, 1'b0);
        pop();
        chk("ovf_pop_empty", evt_valid, 1'b0);
        chk("ovf_sticky", evt_overflow, 1'b1);
        clr();
        chk("ovf_cleared", evt_overflow, 1'b0);

        // push and pop in the same cycle while full
        send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
        evt_ready = 1'b1; rx_data = 8'h29; rx_valid = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0; rx_valid = 1'b0;
        chk("pp_ovf", evt_overflow, 1'b0);
        chk("pp_head", evt_index, 3'd1);
        chk("pp_held", key_held, 8'h1F);
        pop(); pop(); pop();
        chk("pp_last", evt_index, 3'd4);
        chk("pp_last_valid", evt_valid, 1'b1);
        pop();
        chk("pp_empty", evt_valid, 1'b0);

        // prefix timeout boundary
        clr();
        send(8'hE0);
        repeat (15) @(negedge clk);
        send(8'h1D);
        chk("to_early_held", key_held, 8'h00);
        chk("to_early_make", key_make, 8'h00);
        send(8'hE0);
        repeat (16) @(negedge clk);
        send(8'h1D);
        chk("to_held", key_held, 8'h01);
        chk("to_make", key_make, 8'h01);

        // clear with a coincident F0
        clr();
        send(8'h1D);
        send(8'h29);
        chk("cl_held", key_held, 8'h11);
        clear = 1'b1; rx_data = 8'hF0; rx_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; rx_valid = 1'b0;
        chk("cl_held0", key_held, 8'h00);
        chk("cl_valid", evt_valid, 1'b0);
        chk("cl_ovf", evt_overflow, 1'b0);
        send(8'h1D);
        chk("cl_make", key_make, 8'h01);
        chk("cl_break", key_break, 8'h00);
        chk("cl_held1", key_held, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
